// File: rtl/router_pkt_source.sv
// router_pkt_source: buffers a host packet and serialises header, payload and parity to the router.
// Optional ROUTER_SRC_PARITY_INJ_EN: inj_parity_err at command accept inverts the transmitted parity byte.
module router_pkt_source #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic [7:0] d_out,
    output logic       pkt_valid,
    output logic       done,
    output logic       cmd_err,
    input  logic       inj_parity_err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0] r_state;
    logic [2:0] w_nxt;
    logic [1:0] r_addr;
    logic [5:0] r_len;
    logic [5:0] r_cnt;
    logic [7:0] r_par;
    logic [7:0] r_d_out;
    logic       r_pkt_valid;
    logic       r_done;
    logic       r_cmd_err;
    logic       r_cmd_ready;
    logic       r_pl_ready;
    logic       r_inj;
    logic [7:0] r_buf [0:MAX_LEN-1];
    logic       w_cmd_acc;
    logic       w_cmd_bad;
    logic       w_pl_wr;
    logic       w_last;
    logic       w_gap_end;
    logic       w_inj_smp;
    logic [7:0] w_par_out;

`ifdef ROUTER_SRC_PARITY_INJ_EN
    assign w_inj_smp = inj_parity_err;
`else
    logic w_unused_inj;
    assign w_unused_inj = inj_parity_err;
    assign w_inj_smp    = 1'b0;
`endif

    assign w_cmd_acc = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
    assign w_cmd_bad = (cmd_addr == 2'd3) || (cmd_len == 6'd0) || (int'(cmd_len) > MAX_LEN);
    assign w_pl_wr   = r_pl_ready && pl_valid;
    assign w_last    = r_cnt == r_len - 6'd1;
    assign w_gap_end = r_cnt == 6'(GAP_CYCLES - 1);
    // Last payload byte is folded in here since r_par only sees it as it is consumed.
    assign w_par_out = r_par ^ r_d_out ^ {8{r_inj}};

    assign d_out     = r_d_out;
    assign pkt_valid = r_pkt_valid;
    assign done      = r_done;
    assign cmd_err   = r_cmd_err;
    assign cmd_ready = r_cmd_ready;
    assign pl_ready  = r_pl_ready;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:    w_nxt = (w_cmd_acc && !w_cmd_bad) ? S_LOAD : S_IDLE;
            S_LOAD:    w_nxt = (w_pl_wr && w_last) ? S_HEADER : S_LOAD;
            S_HEADER:  w_nxt = busy ? S_HEADER : S_PAYLOAD;
            S_PAYLOAD: w_nxt = (!busy && w_last) ? S_PARITY : S_PAYLOAD;
            S_PARITY:  w_nxt = busy ? S_PARITY : S_GAP;
            S_GAP:     w_nxt = w_gap_end ? S_DONE : S_GAP;
            default:   w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_pl_wr) r_buf[r_cnt] <= pl_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 2'd0;
            r_len       <= 6'd0;
            r_cnt       <= 6'd0;
            r_par       <= 8'd0;
            r_d_out     <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_pl_ready  <= 1'b0;
            r_inj       <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cmd_ready <= w_nxt == S_IDLE;
            r_pl_ready  <= w_nxt == S_LOAD;
            r_done      <= w_nxt == S_DONE;
            r_cmd_err   <= w_cmd_acc && w_cmd_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc && !w_cmd_bad) begin
                        r_addr <= cmd_addr;
                        r_len  <= cmd_len;
                        r_cnt  <= 6'd0;
                        r_inj  <= w_inj_smp;
                    end
                end
                S_LOAD: begin
                    if (w_pl_wr && w_last) begin
                        r_d_out     <= {r_len, r_addr};
                        r_par       <= {r_len, r_addr};
                        r_pkt_valid <= 1'b1;
                        r_cnt       <= 6'd0;
                    end else if (w_pl_wr) begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_HEADER: begin
                    if (!busy) r_d_out <= r_buf[0];
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        r_par <= r_par ^ r_d_out;
                        if (w_last) begin
                            r_d_out     <= w_par_out;
                            r_pkt_valid <= 1'b0;
                            r_cnt       <= 6'd0;
                        end else begin
                            r_d_out <= r_buf[r_cnt + 6'd1];
                            r_cnt   <= r_cnt + 6'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) r_d_out <= 8'd0;
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_source.sv
// tb_router_pkt_source: directed and randomized packets checked against a queue-based byte-stream model.
module tb_router_pkt_source;
    localparam int GAP = 2;
`ifdef ROUTER_SRC_PARITY_INJ_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = 2'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] pl_data = 8'd0;
    logic       busy = 1'b0;
    logic [7:0] d_out;
    logic       pkt_valid;
    logic       done;
    logic       cmd_err;
    logic       inj_parity_err = 1'b0;
    int         nchk = 0;
    int         nfail = 0;

    always #5 clk = ~clk;

    router_pkt_source #(.MAX_LEN(63), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .pl_data(pl_data), .busy(busy), .d_out(d_out), .pkt_valid(pkt_valid),
        .done(done), .cmd_err(cmd_err), .inj_parity_err(inj_parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
    endtask

    // dmode: 0 random bytes, 1 byte=index, 2 byte=0x11*(index+1)
    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                           input bit rnd, input int stall_pos, input int dmode);
        logic [7:0] q[$];
        logic [7:0] p;
        logic [7:0] d;
        logic       b;
        int         pos = 0;
        int         st = 0;
        int         guard = 0;
        wait_ready;
        p = {l, a};
        q.push_back(p);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; inj_parity_err = inj;
        tick;
        cmd_valid = 1'b0; inj_parity_err = 1'b0;
        check("cmd_ready_load", 32'(cmd_ready), 0);
        for (int i = 0; i < int'(l);) begin
            check("pl_ready_load", 32'(pl_ready), 1);
            pl_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = (dmode == 1) ? 8'(i) : (dmode == 2) ? 8'((i + 1) * 17) : 8'($urandom);
            pl_data = d;
            tick;
            if (pl_valid) begin
                q.push_back(d);
                p ^= d;
                i++;
            end
        end
        pl_valid = 1'b0;
        q.push_back(p ^ ((inj && INJ_EN) ? 8'hFF : 8'h00));
        while (q.size() > 0 && guard < 2000) begin
            check("d_out", 32'(d_out), 32'(q[0]));
            check("pkt_valid", 32'(pkt_valid), 32'(q.size() > 1));
            check("cmd_err_tx", 32'(cmd_err), 0);
            if (pos == stall_pos && st < 5) begin
                b = 1'b1;
                st++;
            end else begin
                b = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            busy = b;
            cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_addr = 2'd3;
            tick;
            if (!b) begin
                void'(q.pop_front());
                pos++;
            end
            guard++;
        end
        cmd_valid = 1'b0;
        check("tx_complete", 32'(q.size()), 0);
        for (int g = 0; g < GAP; g++) begin
            check("gap_d_out", 32'(d_out), 0);
            check("gap_pkt_valid", 32'(pkt_valid), 0);
            check("gap_done", 32'(done), 0);
            busy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
        end
        check("done_pulse", 32'(done), 1);
        busy = 1'b0;
        tick;
        check("done_clear", 32'(done), 0);
        check("cmd_ready_after", 32'(cmd_ready), 1);
    endtask

    task automatic bad_cmd(input logic [1:0] a, input logic [5:0] l);
        wait_ready;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        tick;
        cmd_valid = 1'b0;
        check("cmd_err_pulse", 32'(cmd_err), 1);
        check("bad_cmd_ready", 32'(cmd_ready), 1);
        check("bad_pl_ready", 32'(pl_ready), 0);
        tick;
        check("cmd_err_clear", 32'(cmd_err), 0);
        check("bad_pl_ready2", 32'(pl_ready), 0);
    endtask

    initial begin
        #3;
        check("rst_d_out", 32'(d_out), 0);
        check("rst_pkt_valid", 32'(pkt_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cmd_err", 32'(cmd_err), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_pl_ready", 32'(pl_ready), 0);
        tick;
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        run_pkt(2'd1, 6'd3, 1'b0, 1'b0, -1, 2);
        run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 2, 2);
        bad_cmd(2'd3, 6'd4);
        bad_cmd(2'd0, 6'd0);
        run_pkt(2'd2, 6'd63, 1'b0, 1'b0, -1, 1);
        run_pkt(2'd1, 6'd3, 1'b1, 1'b0, -1, 2);
        for (int k = 0; k < 8; k++)
            run_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 1'($urandom_range(0, 1)),
                    1'b1, -1, 0);

        wait_ready;
        cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd5;
        tick;
        cmd_valid = 1'b0;
        pl_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pl_data = 8'(8'hA0 + i);
            tick;
        end
        pl_valid = 1'b0;
        check("mid_header", 32'(d_out), 32'(8'h14));
        tick;
        check("mid_payload", 32'(d_out), 32'(8'hA0));
        check("mid_pkt_valid", 32'(pkt_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("abort_pkt_valid", 32'(pkt_valid), 0);
        check("abort_d_out", 32'(d_out), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("post_rst_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 6; i++) begin
            check("post_rst_no_done", 32'(done), 0);
            check("post_rst_no_valid", 32'(pkt_valid), 0);
            tick;
        end
        run_pkt(2'd1, 6'd3, 1'b0, 1'b1, -1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
